// File: rtl/hist_sched.sv
// hist_sched: per-frame sequencer for the histogram datapath.
// Clears the bin memory, streams NWORDS input words into it, then steps the
// prefix-sum accumulator chunk by chunk and hands each result downstream
// over a valid/ready handshake.
module hist_sched #(
   parameter int NWORDS = 32,
   parameter int CHUNKS = 32
) (
   input  logic         wrclk,
   input  logic         rst,
   input  logic         start,
   input  logic         in_valid,
   input  logic [127:0] in_data,
   output logic         in_ready,
   output logic         mem_clr,
   output logic         mem_wd,
   output logic [127:0] mem_data,
   output logic         acc_en,
   output logic [4:0]   acc_idx,
   input  logic [127:0] acc_out,
   output logic         out_valid,
   output logic [127:0] out_data,
   output logic         out_last,
   input  logic         out_ready,
   output logic         busy,
   output logic         done
);

   localparam int WCW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [WCW-1:0] WORD_LAST  = WCW'(NWORDS - 1);
   localparam logic [4:0]     CHUNK_LAST = 5'(CHUNKS - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_LOAD  = 3'd2,
      ST_ACCUM = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [WCW-1:0] word_cnt;
   logic [4:0]     chunk_cnt;
   logic           pend;
   logic           handshake;

   // The chunk counter doubles as the step index; it only moves on a handshake,
   // so it also identifies the chunk currently held in out_data.
   assign acc_idx  = chunk_cnt;
   assign out_last = out_valid & (chunk_cnt == CHUNK_LAST);

   // Next-state decode and state-derived control outputs.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      mem_clr    = 1'b0;
      mem_wd     = 1'b0;
      mem_data   = 128'd0;
      acc_en     = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      handshake  = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = ST_CLEAR;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            mem_clr    = 1'b1;
            state_next = ST_LOAD;
         end
         ST_LOAD: begin
            in_ready = 1'b1;
            mem_wd   = in_valid;
            mem_data = in_data;
            if (in_valid && (word_cnt == WORD_LAST)) begin
               state_next = ST_ACCUM;
            end else begin
               state_next = ST_LOAD;
            end
         end
         ST_ACCUM: begin
            // A new step is issued only once the previous result has left.
            acc_en    = ~pend & ~out_valid;
            handshake = out_valid & out_ready;
            if (handshake && (chunk_cnt == CHUNK_LAST)) begin
               state_next = ST_DONE;
            end else begin
               state_next = ST_ACCUM;
            end
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            busy       = 1'b0;
            state_next = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge wrclk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Word and chunk counters; both wrap to zero on the last item of a frame.
   always_ff @(posedge wrclk) begin
      if (rst || (state == ST_CLEAR)) begin
         word_cnt  <= '0;
         chunk_cnt <= 5'd0;
      end else begin
         if (mem_wd) begin
            word_cnt <= (word_cnt == WORD_LAST) ? '0 : word_cnt + 1'b1;
         end
         if (handshake) begin
            chunk_cnt <= (chunk_cnt == CHUNK_LAST) ? 5'd0 : chunk_cnt + 5'd1;
         end
      end
   end

   // Step pipeline: pend marks the cycle acc_out is valid, which is then captured.
   always_ff @(posedge wrclk) begin
      if (rst) begin
         pend      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= 128'd0;
      end else begin
         pend <= acc_en;
         if (pend) begin
            out_valid <= 1'b1;
            out_data  <= acc_out;
         end else if (handshake) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hist_sched.sv
// Directed bench for hist_sched (NWORDS=2, CHUNKS=32). Inputs are driven right
// after each falling edge and outputs are checked 1 time unit later.
module tb_hist_sched;

   localparam int NW = 2;
   localparam int NC = 32;
   localparam logic [127:0] W1 = 128'h000C000F00050001000B00030008000A;

   logic         wrclk = 1'b0;
   logic         rst, start, in_valid, out_ready;
   logic [127:0] in_data;
   logic [127:0] acc_out = 128'd0;
   logic         in_ready, mem_clr, mem_wd, acc_en, out_valid, out_last, busy, done;
   logic [127:0] mem_data, out_data;
   logic [4:0]   acc_idx;

   int tests = 0;
   int fails = 0;

   always #5 wrclk = ~wrclk;

   hist_sched #(.NWORDS(NW), .CHUNKS(NC)) dut (
      .wrclk(wrclk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_clr(mem_clr), .mem_wd(mem_wd), .mem_data(mem_data),
      .acc_en(acc_en), .acc_idx(acc_idx), .acc_out(acc_out), .out_valid(out_valid),
      .out_data(out_data), .out_last(out_last), .out_ready(out_ready), .busy(busy), .done(done)
   );

   // Reference accumulator result for a chunk: lane k = 0x1000 + 8*idx + k.
   function automatic logic [127:0] model(input logic [4:0] idx);
      logic [127:0] r;
      r = 128'd0;
      for (int k = 0; k < 8; k++) begin
         r[16*k +: 16] = 16'h1000 + {11'd0, idx} * 16'd8 + 16'(k);
      end
      return r;
   endfunction

   // Accumulator stand-in: result valid the cycle after acc_en, garbage otherwise.
   always @(posedge wrclk) begin
      acc_out <= acc_en ? model(acc_idx) : 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
   end

   task automatic load_frame();
      @(negedge wrclk); start = 1'b1; in_valid = 1'b0;
      @(negedge wrclk); start = 1'b0;
      @(negedge wrclk); in_valid = 1'b1; in_data = 128'd0;
      @(negedge wrclk); in_data = W1;
   endtask

   task automatic finish_frame(input string name);
      int n;
      n = 0;
      do begin
         @(negedge wrclk); out_ready = 1'b1; in_valid = 1'b0; start = 1'b0; #1;
         n++;
      end while (!done && n < 300);
      tests++;
      if (done !== 1'b1) begin
         fails++; $display("FAIL %s_done_timeout got=%b want=1", name, done);
      end
   endtask

   task automatic test_reset_state();
      logic [268:0] v;
      @(negedge wrclk); rst = 1'b0; #1;
      v = {in_ready, mem_clr, mem_wd, mem_data, acc_en, acc_idx, out_valid, out_data, out_last, busy, done};
      tests++;
      if (v !== 269'd0) begin fails++; $display("FAIL reset_state got=%h want=0", v); end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      @(negedge wrclk); start = 1'b1; in_valid = 1'b0; #1;
      tests++;
      if ({busy, mem_clr} !== 2'b00) begin fails++; $display("FAIL basic_c0 got=%b want=00", {busy, mem_clr}); end
      @(negedge wrclk); start = 1'b0; #1;
      tests++;
      if ({mem_clr, busy, in_ready, mem_wd} !== 4'b1100) begin
         fails++; $display("FAIL basic_clear got=%b want=1100", {mem_clr, busy, in_ready, mem_wd});
      end
      @(negedge wrclk); in_valid = 1'b1; in_data = 128'd0; #1;
      tests++;
      if ({mem_clr, in_ready, mem_wd} !== 3'b011 || mem_data !== 128'd0) begin
         fails++; $display("FAIL basic_w0 got=%b/%h want=011/0", {mem_clr, in_ready, mem_wd}, mem_data);
      end
      @(negedge wrclk); in_data = W1; #1;
      tests++;
      if (mem_wd !== 1'b1 || mem_data !== W1) begin
         fails++; $display("FAIL basic_w1 got=%b/%h want=1/%h", mem_wd, mem_data, W1);
      end
      @(negedge wrclk); in_valid = 1'b0; #1;
      tests++;
      if ({acc_en, in_ready, mem_wd} !== 3'b100 || acc_idx !== 5'd0) begin
         fails++; $display("FAIL basic_issue got=%b/%0d want=100/0", {acc_en, in_ready, mem_wd}, acc_idx);
      end
      finish_frame("basic");
   endtask

   task automatic test_full_readout();
      logic [4:0] obs, exp;
      out_ready = 1'b1;
      load_frame();
      for (int c = 4; c <= 102; c++) begin
         @(negedge wrclk); in_valid = 1'b0; #1;
         exp = {(c <= 97 && (c - 4) % 3 == 0), (c <= 99 && (c - 4) % 3 == 2),
                (c == 99), (c == 100), (c <= 100)};
         obs = {acc_en, out_valid, out_last, done, busy};
         tests++;
         if (obs !== exp) begin fails++; $display("FAIL full_ctrl cyc=%0d got=%b want=%b", c, obs, exp); end
         if (exp[4]) begin
            tests++;
            if (acc_idx !== 5'((c - 4) / 3)) begin
               fails++; $display("FAIL full_idx cyc=%0d got=%0d want=%0d", c, acc_idx, (c - 4) / 3);
            end
         end
         if (exp[3]) begin
            tests++;
            if (out_data !== model(5'((c - 4) / 3))) begin
               fails++; $display("FAIL full_data cyc=%0d got=%h want=%h", c, out_data, model(5'((c - 4) / 3)));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b1;
      load_frame();
      for (int c = 4; c <= 32; c++) begin
         @(negedge wrclk); in_valid = 1'b0; out_ready = !(c >= 21 && c <= 30); #1;
         if (c >= 21 && c <= 30) begin
            tests++;
            if ({out_valid, acc_en, acc_idx} !== {1'b1, 1'b0, 5'd5} || out_data !== model(5'd5)) begin
               fails++; $display("FAIL bp_hold cyc=%0d got=%b%b/%0d/%h want=10/5/%h",
                                 c, out_valid, acc_en, acc_idx, out_data, model(5'd5));
            end
         end
         if (c == 31) begin
            tests++;
            if ({out_valid, acc_en} !== 2'b10) begin fails++; $display("FAIL bp_release got=%b want=10", {out_valid, acc_en}); end
         end
         if (c == 32) begin
            tests++;
            if (acc_en !== 1'b1 || acc_idx !== 5'd6) begin
               fails++; $display("FAIL bp_next got=%b/%0d want=1/6", acc_en, acc_idx);
            end
         end
      end
      finish_frame("bp");
   endtask

   task automatic test_input_gaps();
      logic [127:0] gd [4];
      logic [3:0]   iv;
      int           pulses;
      gd[0] = 128'h11111111111111111111111111111111; gd[1] = 128'h22222222222222222222222222222222;
      gd[2] = 128'h33333333333333333333333333333333; gd[3] = 128'h44444444444444444444444444444444;
      iv = 4'b0101;
      pulses = 0;
      @(negedge wrclk); start = 1'b1; in_valid = 1'b0;
      @(negedge wrclk); start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge wrclk); in_valid = iv[i]; in_data = gd[i]; #1;
         if (mem_wd === 1'b1) pulses++;
         tests++;
         if (mem_wd !== iv[i] || (iv[i] && mem_data !== gd[i])) begin
            fails++; $display("FAIL gap_wd cyc=%0d got=%b/%h want=%b/%h", i + 2, mem_wd, mem_data, iv[i], gd[i]);
         end
         tests++;
         if (acc_en !== (i == 3)) begin fails++; $display("FAIL gap_accum cyc=%0d got=%b want=%b", i + 2, acc_en, (i == 3)); end
      end
      tests++;
      if (pulses != 2) begin fails++; $display("FAIL gap_pulses got=%0d want=2", pulses); end
      finish_frame("gap");
   endtask

   task automatic test_spurious();
      logic [3:0] obs, exp;
      int         dones;
      dones = 0;
      out_ready = 1'b1;
      for (int c = 0; c <= 102; c++) begin
         @(negedge wrclk); start = (c <= 100); in_valid = 1'b1; in_data = (c == 2) ? W1 : ~W1; #1;
         if (done === 1'b1) dones++;
         exp = {(c == 1), (c == 2 || c == 3), (c == 100), (c >= 1 && c <= 100)};
         obs = {mem_clr, mem_wd, done, busy};
         tests++;
         if (obs !== exp) begin fails++; $display("FAIL spur_ctrl cyc=%0d got=%b want=%b", c, obs, exp); end
      end
      tests++;
      if (dones != 1) begin fails++; $display("FAIL spur_done_count got=%0d want=1", dones); end
   endtask

   task automatic test_reset();
      logic [268:0] v;
      out_ready = 1'b1;
      load_frame();
      for (int c = 4; c <= 17; c++) begin
         @(negedge wrclk); in_valid = 1'b0; rst = (c >= 11 && c <= 13); #1;
         if (c == 14) begin
            v = {in_ready, mem_clr, mem_wd, mem_data, acc_en, acc_idx, out_valid, out_data, out_last, busy, done};
            tests++;
            if (v !== 269'd0) begin fails++; $display("FAIL rst_outputs got=%h want=0", v); end
         end
         if (c > 14) begin
            tests++;
            if ({busy, done} !== 2'b00) begin fails++; $display("FAIL rst_idle cyc=%0d got=%b want=00", c, {busy, done}); end
         end
      end
      load_frame();
      @(negedge wrclk); in_valid = 1'b0; #1;
      tests++;
      if (acc_en !== 1'b1 || acc_idx !== 5'd0) begin fails++; $display("FAIL rst_reissue got=%b/%0d want=1/0", acc_en, acc_idx); end
      @(negedge wrclk);
      @(negedge wrclk); #1;
      tests++;
      if (out_valid !== 1'b1 || out_data !== model(5'd0)) begin
         fails++; $display("FAIL rst_first_data got=%b/%h want=1/%h", out_valid, out_data, model(5'd0));
      end
      finish_frame("rst_frame");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 128'd0; out_ready = 1'b0;
      repeat (3) @(negedge wrclk);
      test_reset_state();
      test_basic();
      test_full_readout();
      test_backpressure();
      test_input_gaps();
      test_spurious();
      test_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hist_sched.md
# hist_sched

Sequencing controller for the histogram datapath. It owns `data_memory` (256 × 16-bit bin counters, written one 128-bit word of eight 16-bit samples at a time) and `acumulator` (prefix-sum over the bins). Per frame it:
- clears the bins;
- streams NWORDS input words into `data_memory`;
- steps the accumulator through the bin array in 8-bin chunks;
- hands each 128-bit result word downstream on a valid/ready handshake.

It sits between the pixel-fetch front end and the equalization write-back stage.

## Interface
Parameters:
- NWORDS, 32, input words per frame (≥1)
- CHUNKS, 32, accumulator steps per frame (256 bins / 8 lanes)

Ports:
- wrclk  in  1  clock; all logic on rising edge. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- in_valid  in  1  input word valid
- in_data  in  128  eight 16-bit samples, lane 0 = bits [15:0]
- in_ready  out  1  controller accepts input word
- mem_clr  out  1  clear all bins of data_memory
- mem_wd  out  1  write enable to data_memory
- mem_data  out  128  word to data_memory
- acc_en  out  1  accumulator step request
- acc_idx  out  5  chunk index for this step (bins 8·idx..8·idx+7)
- acc_out  in  128  accumulator result, valid one cycle after acc_en
- out_valid  out  1  result word valid
- out_data  out  128  result word (8 × 16-bit cumulative counts)
- out_last  out  1  marks chunk CHUNKS-1
- out_ready  in  1  downstream accepts result
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of frame

## Operation
- Reset value of every output is 0. While rst is high:
  - FSM goes to IDLE;
  - word counter, chunk counter, pend flag, output register and out_valid are cleared.
- rst wins over all other inputs in the same cycle. Reset mid-frame aborts the frame silently; done is not pulsed.
- FSM states and transitions:
  - IDLE: start=1 → CLEAR.
  - CLEAR: mem_clr=1 for exactly one cycle → LOAD.
  - LOAD:
    - in_ready=1.
    - mem_wd = in_valid & in_ready (combinational); mem_data = in_data.
    - The word counter increments on each accepted word.
    - The accepted word with count NWORDS-1 → ACCUM (counter cleared).
  - ACCUM:
    - Issue rule: issue a step when pend=0 and out_valid=0. On issue: acc_en=1, acc_idx = chunk counter, pend set.
    - Capture: the cycle after issue, acc_out is latched into out_data, out_valid is set and pend is cleared.
    - out_last=1 while out_data holds chunk CHUNKS-1.
    - An out_valid & out_ready handshake clears out_valid and increments the chunk counter.
    - The handshake of chunk CHUNKS-1 → DONE.
  - DONE: done=1 for one cycle → IDLE.
- start outside IDLE is ignored. in_valid outside LOAD is ignored: in_ready=0 and mem_wd=0.
- acc_idx is a 5-bit value with no wrap beyond CHUNKS-1. acc_idx and out_data hold their values when not updating.
- out_data is stable while out_valid=1 and out_ready=0. Backpressure stalls issue indefinitely.

## Timing
- start at cycle 0:
  - CLEAR in cycle 1 (mem_clr=1);
  - LOAD from cycle 2.
- With continuous in_valid, the last word is accepted in cycle NWORDS+1, and the first acc_en is in cycle NWORDS+2.
- Each chunk takes:
  - issue cycle t;
  - capture edge at the end of t+1, so out_valid=1 from t+2;
  - with out_ready=1, handshake in cycle t+2;
  - next issue in t+3.
- That gives 3 cycles per chunk at full throughput.
- done pulses the cycle after the final handshake. busy drops in the same cycle that done drops.
- in_valid gaps in LOAD simply extend LOAD. No word is lost or duplicated.
- A simultaneous out_ready and capture cannot occur (out_valid=0 at capture).

## Test plan
1. Reset: hold rst 3 cycles mid-ACCUM → next cycle all outputs 0, busy=0. A following start produces a full, normal frame.
2. Basic frame, NWORDS=2:
   - stimulus: start, then words 128'h0 and 128'h000C000F00050001000B00030008000A back to back;
   - required: mem_clr in cycle 1, mem_wd in cycles 2–3 carrying those words, first acc_en with acc_idx=0 in cycle 4.
3. Full readout, out_ready=1, CHUNKS=32:
   - out_data equals acc_out of each step for idx 0..31 in order;
   - out_last only on idx 31;
   - done exactly once, 1 cycle after the last handshake.
4. Backpressure: out_ready=0 for 10 cycles on chunk 5 → out_data stable, no acc_en, acc_idx=5 held. Release → chunk 6 issued 1 cycle after the handshake.
5. Input gaps: in_valid toggling 1,0,1,0 with NWORDS=2 → exactly 2 mem_wd pulses, ACCUM entered the cycle after the second.
6. Spurious controls:
   - start held high through the whole frame → no restart, done once;
   - in_valid=1 during ACCUM → mem_wd stays 0.
